// File: rtl/coin_acceptor.sv
// coin_acceptor: front end for the vending FSM coin inputs.
// Synchronises and debounces the raw nickel/dime sensors, classifies each
// insertion (nickel, dime or reject), queues accepted coins in a small FIFO
// and replays them as single-cycle pulses separated by a guard gap.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sense_nickel, sense_dime raw asynchronous coin sensors (may bounce)
//   hold                     downstream busy; no new pulse starts while high
//   nickel, dime             one-cycle accepted-coin pulses
//   reject                   one-cycle pulse for an invalid insertion
//   overflow                 one-cycle pulse when a valid coin is dropped
//   occupancy                current FIFO entry count
module coin_acceptor #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned GAP      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sense_nickel,
  input  logic                     sense_dime,
  input  logic                     hold,
  output logic                     nickel,
  output logic                     dime,
  output logic                     reject,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned DW       = $clog2(DEBOUNCE + 1);
  localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_GAP
  } state_e;

  // Channel index 0 = nickel, 1 = dime.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [DW-1:0]    db_cnt_q [2];
  logic [DW-1:0]    db_cnt_d [2];

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;

  logic             nickel_q, nickel_d;
  logic             dime_q, dime_d;
  logic             reject_q, reject_d;
  logic             overflow_q, overflow_d;

  logic [1:0]       rise;
  logic             push, push_coin, push_ok, pop, full, start_ok;

  // Synchroniser and per-channel debounce counters.
  always_comb begin
    sync1_d = {sense_dime, sense_nickel};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int ch = 0; ch < 2; ch++) begin
      db_cnt_d[ch] = '0;
      if (sync2_q[ch] != deb_q[ch]) begin
        if (db_cnt_q[ch] == DW'(DEBOUNCE - 1)) begin
          deb_d[ch] = sync2_q[ch];
        end else begin
          db_cnt_d[ch] = db_cnt_q[ch] + DW'(1);
        end
      end
    end
  end

  // Classify on the cycle a debounced level rises; a rise while the other
  // channel is already (or simultaneously) high is an invalid insertion.
  always_comb begin
    rise      = deb_d & ~deb_q;
    push      = 1'b0;
    push_coin = 1'b0;
    reject_d  = 1'b0;
    if (rise == 2'b01 && !deb_q[1]) begin
      push = 1'b1;
    end else if (rise == 2'b10 && !deb_q[0]) begin
      push      = 1'b1;
      push_coin = 1'b1;
    end else if (rise != 2'b00) begin
      reject_d = 1'b1;
    end
  end

  // Output sequencer. The last cycle of the gap doubles as the idle decision
  // point so queued coins go out exactly 1+GAP cycles apart.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    nickel_d  = 1'b0;
    dime_d    = 1'b0;
    start_ok  = 1'b0;
    case (state_q)
      ST_IDLE: start_ok = 1'b1;
      ST_EMIT: begin
        if (GAP == 0) begin
          start_ok = 1'b1;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_LAST)) begin
          start_ok = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_ok) begin
      if (count_q != '0 && !hold) begin
        pop      = 1'b1;
        state_d  = ST_EMIT;
        nickel_d = ~mem_q[rd_ptr_q];
        dime_d   = mem_q[rd_ptr_q];
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Coin FIFO; a pop in the same cycle frees room for a push when full.
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    push_ok    = push && (!full || pop);
    overflow_d = push && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_coin;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      nickel_q    <= 1'b0;
      dime_q      <= 1'b0;
      reject_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      nickel_q    <= nickel_d;
      dime_q      <= dime_d;
      reject_q    <= reject_d;
      overflow_q  <= overflow_d;
    end
  end

  assign nickel    = nickel_q;
  assign dime      = dime_q;
  assign reject    = reject_q;
  assign overflow  = overflow_q;
  assign occupancy = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a behavioural reference model.
module tb_coin_acceptor;

  localparam int DEBOUNCE = 4;
  localparam int DEPTH    = 4;
  localparam int GAP      = 1;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sense_nickel = 1'b0;
  logic          sense_dime = 1'b0;
  logic          hold = 1'b0;
  logic          nickel, dime, reject, overflow;
  logic [CW-1:0] occupancy;

  coin_acceptor #(
    .DEBOUNCE(DEBOUNCE),
    .DEPTH(DEPTH),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sense_nickel(sense_nickel),
    .sense_dime(sense_dime),
    .hold(hold),
    .nickel(nickel),
    .dime(dime),
    .reject(reject),
    .overflow(overflow),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: sensor history, debounce run lengths, a coin queue and
  // the edge number of the last emitted pulse.
  logic [1:0] m_s1 = '0;
  logic [1:0] m_s2 = '0;
  logic [1:0] m_deb = '0;
  int         m_run [2];
  int         m_q [$];
  int         m_edge = 0;
  int         m_last = -100;
  logic       e_nickel = 1'b0;
  logic       e_dime = 1'b0;
  logic       e_reject = 1'b0;
  logic       e_overflow = 1'b0;
  int         e_occ = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [1:0] old_deb;
    logic [1:0] rise;
    int         coin;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_q.delete();
      m_last = -100;
      e_nickel = 1'b0; e_dime = 1'b0; e_reject = 1'b0; e_overflow = 1'b0;
      e_occ = 0;
    end else begin
      m_edge = m_edge + 1;
      old_deb = m_deb;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_s2[ch] != m_deb[ch]) begin
          m_run[ch] = m_run[ch] + 1;
          if (m_run[ch] == DEBOUNCE) begin
            m_deb[ch] = m_s2[ch];
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {sense_dime, sense_nickel};
      rise = m_deb & ~old_deb;
      e_nickel = 1'b0; e_dime = 1'b0; e_reject = 1'b0; e_overflow = 1'b0;
      if (m_q.size() > 0 && !hold && m_edge >= m_last + 1 + GAP) begin
        coin = m_q.pop_front();
        m_last = m_edge;
        e_nickel = (coin == 0);
        e_dime = (coin == 1);
      end
      coin = -1;
      if (rise == 2'b01 && !old_deb[1]) coin = 0;
      else if (rise == 2'b10 && !old_deb[0]) coin = 1;
      else if (rise != 2'b00) e_reject = 1'b1;
      if (coin >= 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(coin);
        else e_overflow = 1'b1;
      end
      e_occ = m_q.size();
    end
  end

  int vec = 0;
  int mis = 0;
  int ncyc = 0;
  int n_rej = 0;
  int n_ovf = 0;
  int obs [$];
  int obs_cyc [$];

  function automatic int obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return -1;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < obs_cyc.size()) return obs_cyc[i];
    return -1000;
  endfunction

  // Advance n cycles, comparing every sample against the model.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
        vec++;
        if ({nickel, dime, reject, overflow} !== {e_nickel, e_dime, e_reject, e_overflow} ||
            occupancy !== CW'(e_occ)) begin
          mis++;
          $display("FAIL model cycle %0d: got n=%b d=%b r=%b o=%b occ=%0d, required n=%b d=%b r=%b o=%b occ=%0d",
                   ncyc, nickel, dime, reject, overflow, occupancy,
                   e_nickel, e_dime, e_reject, e_overflow, e_occ);
        end
        if (nickel) begin obs.push_back(0); obs_cyc.push_back(ncyc); end
        if (dime) begin obs.push_back(1); obs_cyc.push_back(ncyc); end
        if (reject) n_rej++;
        if (overflow) n_ovf++;
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    vec++;
    if (got != exp) begin
      mis++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic insert(input int coin);
    if (coin == 0) sense_nickel = 1'b1; else sense_dime = 1'b1;
    tick(8);
    sense_nickel = 1'b0;
    sense_dime = 1'b0;
    tick(8);
  endtask

  initial begin : stim
    int b, r, o, t0;

    // Reset state
    rst = 1'b1;
    tick(3);
    check("rst_nickel", int'(nickel), 0);
    check("rst_dime", int'(dime), 0);
    check("rst_reject", int'(reject), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_occ", int'(occupancy), 0);
    rst = 1'b0;
    tick(5);

    // Single nickel: pulse after edge 7
    b = obs.size(); r = n_rej; t0 = ncyc;
    sense_nickel = 1'b1;
    tick(6);
    check("nk_occ_push", int'(occupancy), 1);
    check("nk_before", int'(nickel), 0);
    tick(1);
    check("nk_pulse", int'(nickel), 1);
    check("nk_occ_pop", int'(occupancy), 0);
    tick(1);
    check("nk_one_cycle", int'(nickel), 0);
    tick(2);
    sense_nickel = 1'b0;
    tick(12);
    check("nk_count", obs.size() - b, 1);
    check("nk_kind", obs_at(b), 0);
    check("nk_latency", cyc_at(b) - t0, 7);
    check("nk_no_reject", n_rej - r, 0);

    // Bounce 1-0-1 then settle
    b = obs.size();
    sense_nickel = 1'b1; tick(1);
    sense_nickel = 1'b0; tick(1);
    sense_nickel = 1'b1; tick(10);
    sense_nickel = 1'b0; tick(12);
    check("bounce_count", obs.size() - b, 1);
    check("bounce_kind", obs_at(b), 0);

    // Glitch rejection
    b = obs.size(); r = n_rej;
    sense_dime = 1'b1; tick(2);
    sense_dime = 1'b0; tick(12);
    check("glitch_pulses", obs.size() - b, 0);
    check("glitch_reject", n_rej - r, 0);
    check("glitch_occ", int'(occupancy), 0);

    // Both sensors rise together
    b = obs.size(); r = n_rej;
    sense_nickel = 1'b1; sense_dime = 1'b1;
    tick(6);
    check("both_reject_at_edge6", int'(reject), 1);
    check("both_occ", int'(occupancy), 0);
    tick(1);
    check("both_reject_one_cycle", int'(reject), 0);
    tick(4);
    sense_nickel = 1'b0; sense_dime = 1'b0;
    tick(12);
    check("both_reject_count", n_rej - r, 1);
    check("both_no_push", obs.size() - b, 0);

    // Dime held, then nickel rises
    b = obs.size(); r = n_rej;
    sense_dime = 1'b1; tick(10);
    sense_nickel = 1'b1; tick(10);
    check("dn_occ", int'(occupancy), 0);
    sense_nickel = 1'b0; sense_dime = 1'b0;
    tick(12);
    check("dn_reject_count", n_rej - r, 1);
    check("dn_pulses", obs.size() - b, 1);
    check("dn_kind", obs_at(b), 1);

    // Hold and ordering
    b = obs.size();
    hold = 1'b1;
    insert(0); insert(1); insert(0);
    check("hold_occ", int'(occupancy), 3);
    check("hold_no_pulse", obs.size() - b, 0);
    hold = 1'b0;
    tick(10);
    check("order_count", obs.size() - b, 3);
    check("order_0", obs_at(b), 0);
    check("order_1", obs_at(b + 1), 1);
    check("order_2", obs_at(b + 2), 0);
    check("spacing_01", cyc_at(b + 1) - cyc_at(b), 2);
    check("spacing_12", cyc_at(b + 2) - cyc_at(b + 1), 2);
    check("order_occ", int'(occupancy), 0);

    // Overflow
    b = obs.size(); o = n_ovf;
    hold = 1'b1;
    insert(0); insert(1); insert(1); insert(0); insert(1);
    check("ovf_occ", int'(occupancy), 4);
    check("ovf_count", n_ovf - o, 1);
    check("ovf_no_pulse", obs.size() - b, 0);
    hold = 1'b0;
    tick(12);
    check("ovf_drain", obs.size() - b, 4);
    check("ovf_q0", obs_at(b), 0);
    check("ovf_q1", obs_at(b + 1), 1);
    check("ovf_q2", obs_at(b + 2), 1);
    check("ovf_q3", obs_at(b + 3), 0);
    check("ovf_occ_end", int'(occupancy), 0);

    // Reset mid-operation with coins queued and a pulse high
    hold = 1'b1;
    insert(0); insert(1); insert(0);
    hold = 1'b0;
    tick(1);
    check("mid_pulse_high", int'(nickel), 1);
    check("mid_occ", int'(occupancy), 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_nickel", int'(nickel), 0);
    check("mid_rst_dime", int'(dime), 0);
    check("mid_rst_occ", int'(occupancy), 0);
    tick(1);
    rst = 1'b0;
    b = obs.size();
    tick(20);
    check("post_rst_pulses", obs.size() - b, 0);
    check("post_rst_occ", int'(occupancy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
